uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx serializer between two byte requesters:
  - the CPU display path (DDR writes, with DSR ready semantics);
  - a debug trace source (state/bus dump bytes).
- Each requester has a one-byte holding register.
- A sequencing FSM launches one byte at a time into uart_tx and waits for completion.
- Sits between the datapath/display-output logic and uart_tx in the top level.

Parameters:
- CPU_PRIORITY, 1: 1 = CPU wins ties subject to the burst limit; 0 = strict round-robin alternation.
- MAX_CPU_BURST, 4: consecutive CPU grants allowed while debug is pending before debug is forced a grant (range 1-15).
- GAP_CYCLES, 2: idle cycles between tx_done and the next launch (range 0-15).
- TIMEOUT_CYCLES, 200000: watchdog limit (used only with ARB_TIMEOUT_EN).

Ports:
- i_Clk  in  1  system clock
- reset_  in  1  asynchronous, active-high reset
- cpu_req  in  1  one-cycle DDR write strobe
- cpu_byte  in  8  byte to display, sampled with cpu_req
- cpu_ready  out  1  DSR[15]; 1 = CPU holding register empty
- dbg_req  in  1  debug byte valid; held until dbg_ack
- dbg_byte  in  8  debug byte, stable while dbg_req=1
- dbg_ack  out  1  one-cycle pulse when dbg_byte is latched
- tx_dv  out  1  to uart_tx i_Tx_DV
- tx_byte  out  8  to uart_tx i_Tx_Byte
- tx_active  in  1  from uart_tx o_Tx_Active
- tx_done  in  1  from uart_tx o_Tx_Done
- grant  out  2  00 none, 01 CPU, 10 debug (current owner)
- err  out  1  sticky timeout flag; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset values: cpu_ready=1, dbg_ack=0, tx_dv=0, tx_byte=0, grant=00, err=0, holding registers empty, burst counter 0, last_grant=debug, FSM in IDLE.
- CPU holding register:
  - cpu_req with cpu_ready=1 latches cpu_byte; cpu_ready=0 from the next cycle.
  - cpu_req with cpu_ready=0 is ignored; the byte is dropped and the register is unchanged.
- Debug holding register:
  - When the register is empty and dbg_req=1, latch dbg_byte and pulse dbg_ack for one cycle.
  - At most one ack per latched byte.
- FSM states: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE:
  - Stays in IDLE if tx_active=1.
  - Otherwise, if any holding register is full, pick a winner and go to LAUNCH.
- LAUNCH (1 cycle):
  - tx_dv=1; tx_byte = winner's byte; grant = winner.
  - Next state is WAIT_DONE.
- WAIT_DONE:
  - tx_byte and grant stay stable.
  - On tx_done: clear the winner's register (cpu_ready=1 on the next cycle if the winner was CPU), then go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP: count GAP_CYCLES, then go to IDLE; grant=00.
- Arbitration, CPU_PRIORITY=1:
  - CPU wins if full, unless debug is full and burst counter = MAX_CPU_BURST.
  - Burst counter increments on each CPU grant while debug is full, and clears on any debug grant.
- Arbitration, CPU_PRIORITY=0: if both are full, grant the one not in last_grant.
- Latency: cpu_req in an idle system gives tx_dv 2 cycles after the strobe (latch, IDLE decision, LAUNCH).
- Boundary conditions:
  - tx_done outside WAIT_DONE is ignored.
  - A new cpu_req in the same cycle as its own register clears is ignored, because cpu_ready is still 0.
  - A debug latch coinciding with a launch is allowed, since the registers are independent.
- Reset mid-transfer:
  - All state returns to reset values immediately.
  - The first post-reset launch waits for tx_active=0.

Optional Feature:
- Macro: UART_TX_ARBITER_TIMEOUT_EN.
- When defined:
  - A watchdog counter runs in WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES without tx_done: set err (sticky until reset), discard the winner's byte (cpu_ready=1 if the winner was CPU), and go to GAP.
- When undefined: no counter; WAIT_DONE waits indefinitely; err is tied to 0.

Decomposition:
- Shared package (lc3_io_pkg):
  - FSM state encoding;
  - grant encodings GRANT_NONE/CPU/DBG;
  - the DSR ready-bit index (15).
- One sub-module, tx_holding_reg: an 8-bit holding register with full flag, load and clear. Instantiated twice (CPU, debug).
- The arbitration and FSM logic stay in the top module.

Test Plan:
- CPU only: cpu_req with 0x41 → cpu_ready=0 next cycle; tx_dv pulse 2 cycles after the strobe with tx_byte=0x41, grant=01; tx_done → cpu_ready=1 on the next cycle.
- Overrun: second cpu_req with 0x42 while cpu_ready=0 → ignored; only 0x41 is transmitted.
- Burst limit, CPU_PRIORITY=1, MAX_CPU_BURST=4:
  - Stimulus: continuous CPU traffic with dbg_req held and dbg_byte=0x7E.
  - Required: grants run CPU×4, then debug (0x7E), then CPU again; dbg_ack is a single pulse.
- Round-robin, CPU_PRIORITY=0, both requesters always full: grant alternates 01, 10, 01, 10.
- Gap/active: GAP_CYCLES=2 → exactly 2 idle cycles between tx_done and the next tx_dv; with tx_active held at 1, no launch occurs.
- Reset mid-WAIT_DONE: assert reset_ → all outputs return to reset values asynchronously.
- Timeout, macro defined, TIMEOUT_CYCLES=50: tx_done withheld → err=1 at cycle 50, cpu_ready=1, FSM proceeds.

Source files
------------

// File: rtl/lc3_io_pkg.sv
`default_nettype none
// ============================================================================
// Package : lc3_io_pkg
// Shared encodings for the LC-3 I/O blocks (UART TX arbiter FSM, grants, DSR).
// Rev     : 1.0
// ============================================================================
package lc3_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_CPU  = 2'b01;
    localparam logic [1:0] GRANT_DBG  = 2'b10;

    // Bit of the display status register that mirrors cpu_ready.
    localparam int DSR_READY_BIT = 15;

endpackage
`default_nettype wire

// File: rtl/tx_holding_reg.sv
`default_nettype none
// ============================================================================
// Module : tx_holding_reg
// One-byte holding register with full flag; clear wins over load.
// Rev    : 1.0
// ============================================================================
module tx_holding_reg (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       clear_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       full_o
);

    logic [7:0] data_q;
    logic       full_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            data_q <= data_i;
            full_q <= 1'b1;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_arbiter
// Shares one uart_tx between the CPU display path and a debug trace source.
// Optional watchdog enabled by macro UART_TX_ARBITER_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int CPU_PRIORITY   = 1,
    parameter int MAX_CPU_BURST  = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       i_Clk,
    input  logic       reset_,
    input  logic       cpu_req,
    input  logic [7:0] cpu_byte,
    output logic       cpu_ready,
    input  logic       dbg_req,
    input  logic [7:0] dbg_byte,
    output logic       dbg_ack,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic [1:0] grant,
    output logic       err
);
    import lc3_io_pkg::*;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_CPU_BURST);
    localparam logic [3:0] GAP_LAST    = 4'(GAP_CYCLES - 1);

    arb_state_t state_q, state_d;
    logic [1:0] winner_q, winner_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic [3:0] burst_q, burst_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       last_dbg_q, last_dbg_d;
    logic       dbg_ack_q;

    logic       cpu_full, dbg_full, cpu_load, dbg_load, cpu_clr, dbg_clr;
    logic       cpu_wins, timeout;
    logic [7:0] cpu_data, dbg_data;

    // Loads only into an empty register, so an overrun strobe is simply dropped.
    assign cpu_load = cpu_req & ~cpu_full;
    assign dbg_load = dbg_req & ~dbg_full;

    tx_holding_reg u_cpu_hold (
        .clk_i   (i_Clk),
        .rst_i   (reset_),
        .load_i  (cpu_load),
        .clear_i (cpu_clr),
        .data_i  (cpu_byte),
        .data_o  (cpu_data),
        .full_o  (cpu_full)
    );

    tx_holding_reg u_dbg_hold (
        .clk_i   (i_Clk),
        .rst_i   (reset_),
        .load_i  (dbg_load),
        .clear_i (dbg_clr),
        .data_i  (dbg_byte),
        .data_o  (dbg_data),
        .full_o  (dbg_full)
    );

    always_comb begin
        if (CPU_PRIORITY != 0) begin
            cpu_wins = cpu_full && !(dbg_full && (burst_q == BURST_LIMIT));
        end else begin
            cpu_wins = cpu_full && (!dbg_full || last_dbg_q);
        end
    end

    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        tx_byte_d  = tx_byte_q;
        burst_d    = burst_q;
        gap_cnt_d  = gap_cnt_q;
        last_dbg_d = last_dbg_q;
        cpu_clr    = 1'b0;
        dbg_clr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!tx_active && (cpu_full || dbg_full)) begin
                    state_d = ST_LAUNCH;
                    if (cpu_wins) begin
                        winner_d   = GRANT_CPU;
                        tx_byte_d  = cpu_data;
                        last_dbg_d = 1'b0;
                        if (dbg_full && (burst_q != 4'hF)) begin
                            burst_d = burst_q + 4'd1;
                        end
                    end else begin
                        winner_d   = GRANT_DBG;
                        tx_byte_d  = dbg_data;
                        last_dbg_d = 1'b1;
                        burst_d    = '0;
                    end
                end
            end
            ST_LAUNCH: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (tx_done || timeout) begin
                    cpu_clr   = (winner_q == GRANT_CPU);
                    dbg_clr   = (winner_q == GRANT_DBG);
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge reset_) begin
        if (reset_) begin
            state_q    <= ST_IDLE;
            winner_q   <= GRANT_NONE;
            tx_byte_q  <= '0;
            burst_q    <= '0;
            gap_cnt_q  <= '0;
            last_dbg_q <= 1'b1;
            dbg_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            winner_q   <= winner_d;
            tx_byte_q  <= tx_byte_d;
            burst_q    <= burst_d;
            gap_cnt_q  <= gap_cnt_d;
            last_dbg_q <= last_dbg_d;
            dbg_ack_q  <= dbg_load;
        end
    end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    // Fires on the TIMEOUT_CYCLES-th WAIT_DONE cycle that sees no tx_done.
    assign timeout = (state_q == ST_WAIT_DONE) && !tx_done && (wd_q == WD_LAST);

    always_ff @(posedge i_Clk or posedge reset_) begin
        if (reset_) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q <= (state_q == ST_WAIT_DONE) ? wd_q + 1'b1 : '0;
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign cpu_ready = ~cpu_full;
    assign dbg_ack   = dbg_ack_q;
    assign tx_dv     = (state_q == ST_LAUNCH);
    assign tx_byte   = tx_byte_q;
    assign grant     = ((state_q == ST_LAUNCH) || (state_q == ST_WAIT_DONE)) ? winner_q : GRANT_NONE;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_uart_tx_arbiter
// Self-checking bench: priority instance plus a round-robin instance.
// Rev    : 1.0
// ============================================================================
module tb_uart_tx_arbiter;
    import lc3_io_pkg::*;

    localparam int GAP = 2;
    localparam int TMO = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Priority instance
    logic       cpu_req   = 1'b0;
    logic [7:0] cpu_byte  = 8'h00;
    logic       dbg_req   = 1'b0;
    logic [7:0] dbg_byte  = 8'h00;
    logic       h_active  = 1'b0;
    logic       h_done    = 1'b0;
    logic       auto_uart = 1'b0;
    logic       m_active  = 1'b0;
    logic       m_done    = 1'b0;
    logic       tx_active, tx_done;
    logic       cpu_ready, dbg_ack, tx_dv, err;
    logic [7:0] tx_byte;
    logic [1:0] grant;

    assign tx_active = auto_uart ? m_active : h_active;
    assign tx_done   = auto_uart ? m_done   : h_done;

    // Round-robin instance
    logic       rr_run      = 1'b0;
    logic       r_cpu_req   = 1'b0;
    logic [7:0] r_cpu_byte  = 8'h00;
    logic [7:0] r_cpu_seq   = 8'h10;
    logic       r_dbg_req   = 1'b0;
    logic [7:0] r_dbg_byte  = 8'hD0;
    logic       r_tx_active = 1'b0;
    logic       r_tx_done   = 1'b0;
    logic       r_cpu_ready, r_dbg_ack, r_tx_dv, r_err;
    logic [7:0] r_tx_byte;
    logic [1:0] r_grant;

    uart_tx_arbiter #(
        .CPU_PRIORITY(1), .MAX_CPU_BURST(4), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_Clk(clk), .reset_(rst),
        .cpu_req(cpu_req), .cpu_byte(cpu_byte), .cpu_ready(cpu_ready),
        .dbg_req(dbg_req), .dbg_byte(dbg_byte), .dbg_ack(dbg_ack),
        .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_active(tx_active), .tx_done(tx_done),
        .grant(grant), .err(err)
    );

    uart_tx_arbiter #(
        .CPU_PRIORITY(0), .MAX_CPU_BURST(4), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut_rr (
        .i_Clk(clk), .reset_(rst),
        .cpu_req(r_cpu_req), .cpu_byte(r_cpu_byte), .cpu_ready(r_cpu_ready),
        .dbg_req(r_dbg_req), .dbg_byte(r_dbg_byte), .dbg_ack(r_dbg_ack),
        .tx_dv(r_tx_dv), .tx_byte(r_tx_byte), .tx_active(r_tx_active), .tx_done(r_tx_done),
        .grant(r_grant), .err(r_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_dv(input int max_cycles, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            seen = tx_dv;
        end
        check(name, {31'd0, seen}, 1);
    endtask

    // Scoreboard: expected {grant, byte} pushed at stimulus, popped at each tx_dv
    typedef struct packed { logic [1:0] g; logic [7:0] b; } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   dv_count  = 0;
    int   ack_count = 0;

    always @(negedge clk) begin
        if (!rst && dbg_ack) ack_count++;
        if (!rst && tx_dv) begin
            dv_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_launch: byte 0x%0h grant %0d, nothing expected", tx_byte, grant);
            end else begin
                mon_e = sb.pop_front();
                check("launch_grant", {30'd0, grant}, {30'd0, mon_e.g});
                check("launch_byte", {24'd0, tx_byte}, {24'd0, mon_e.b});
            end
        end
    end

    // Behavioural uart_tx: active after DV, done pulse 3 cycles later
    always @(negedge clk) begin
        if (auto_uart && tx_dv && !rst) begin
            m_active = 1'b1;
            repeat (3) @(negedge clk);
            m_done = 1'b1;
            @(negedge clk);
            m_done   = 1'b0;
            m_active = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (r_tx_dv && !rst) begin
            r_tx_active = 1'b1;
            repeat (3) @(negedge clk);
            r_tx_done = 1'b1;
            @(negedge clk);
            r_tx_done   = 1'b0;
            r_tx_active = 1'b0;
        end
    end

    // Round-robin sources keep both holding registers refilled
    logic [1:0] rr_grants[$];
    always @(negedge clk) begin
        r_cpu_req = rr_run && r_cpu_ready;
        if (r_cpu_req) begin
            r_cpu_byte = r_cpu_seq;
            r_cpu_seq  = r_cpu_seq + 8'd1;
        end
        r_dbg_req = rr_run;
        if (r_dbg_ack) r_dbg_byte = r_dbg_byte + 8'd1;
        if (!rst && r_tx_dv) rr_grants.push_back(r_grant);
    end

    typedef struct {
        logic [7:0] b;
        logic       overrun;
        logic [7:0] b2;
        logic       early_done;
        logic       req_on_clear;
        logic [1:0] exp_grant;
        logic [7:0] exp_byte;
        logic       exp_ready_end;
    } vec_t;

    vec_t vecs[4];
    int   sent, ack0, dv0, gap_k;

    initial begin
        vecs[0] = '{8'h41, 1'b0, 8'h00, 1'b0, 1'b0, GRANT_CPU, 8'h41, 1'b1};
        vecs[1] = '{8'h41, 1'b1, 8'h42, 1'b0, 1'b0, GRANT_CPU, 8'h41, 1'b1};
        vecs[2] = '{8'hC3, 1'b0, 8'h00, 1'b1, 1'b1, GRANT_CPU, 8'hC3, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, GRANT_CPU, 8'h00, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_cpu_ready", {31'd0, cpu_ready}, 1);
        check("rst_dbg_ack", {31'd0, dbg_ack}, 0);
        check("rst_tx_dv", {31'd0, tx_dv}, 0);
        check("rst_tx_byte", {24'd0, tx_byte}, 0);
        check("rst_grant", {30'd0, grant}, {30'd0, GRANT_NONE});
        check("rst_err", {31'd0, err}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single CPU transfers: latency, overrun drop, stray tx_done, req on clear
        for (int i = 0; i < 4; i++) begin
            cpu_req  = 1'b1;
            cpu_byte = vecs[i].b;
            h_done   = vecs[i].early_done;
            sb.push_back('{vecs[i].exp_grant, vecs[i].exp_byte});
            @(negedge clk);
            cpu_req  = vecs[i].overrun;
            cpu_byte = vecs[i].b2;
            h_done   = 1'b0;
            check($sformatf("v%0d_ready_low", i), {31'd0, cpu_ready}, 0);
            check($sformatf("v%0d_no_early_dv", i), {31'd0, tx_dv}, 0);
            @(negedge clk);
            cpu_req = 1'b0;
            check($sformatf("v%0d_dv_latency", i), {31'd0, tx_dv}, 1);
            @(negedge clk);
            h_done   = 1'b1;
            cpu_req  = vecs[i].req_on_clear;
            cpu_byte = 8'hEE;
            check($sformatf("v%0d_grant_wait", i), {30'd0, grant}, {30'd0, vecs[i].exp_grant});
            check($sformatf("v%0d_ready_wait", i), {31'd0, cpu_ready}, 0);
            @(negedge clk);
            h_done  = 1'b0;
            cpu_req = 1'b0;
            check($sformatf("v%0d_ready_end", i), {31'd0, cpu_ready}, {31'd0, vecs[i].exp_ready_end});
            check($sformatf("v%0d_grant_gap", i), {30'd0, grant}, {30'd0, GRANT_NONE});
            repeat (5) @(negedge clk);
        end

        // Asynchronous reset in WAIT_DONE
        cpu_req  = 1'b1;
        cpu_byte = 8'hA5;
        sb.push_back('{GRANT_CPU, 8'hA5});
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rstmid_grant_before", {30'd0, grant}, {30'd0, GRANT_CPU});
        #2 rst = 1'b1;
        #1;
        check("rstmid_cpu_ready", {31'd0, cpu_ready}, 1);
        check("rstmid_dbg_ack", {31'd0, dbg_ack}, 0);
        check("rstmid_tx_dv", {31'd0, tx_dv}, 0);
        check("rstmid_tx_byte", {24'd0, tx_byte}, 0);
        check("rstmid_grant", {30'd0, grant}, {30'd0, GRANT_NONE});
        check("rstmid_err", {31'd0, err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // tx_active held high blocks the launch
        h_active = 1'b1;
        cpu_req  = 1'b1;
        cpu_byte = 8'h3C;
        sb.push_back('{GRANT_CPU, 8'h3C});
        dv0 = dv_count;
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (8) @(negedge clk);
        check("no_launch_while_active", dv_count, dv0);
        h_active = 1'b0;
        wait_dv(4, "launch_after_active");

        // Gap timing: tx_done -> GAP cycles -> IDLE decision -> LAUNCH
        @(negedge clk);
        h_done = 1'b1;
        @(negedge clk);
        h_done = 1'b0;
        check("gap_ready_after_done", {31'd0, cpu_ready}, 1);
        cpu_req  = 1'b1;
        cpu_byte = 8'h5A;
        sb.push_back('{GRANT_CPU, 8'h5A});
        gap_k = 1;
        @(negedge clk);
        cpu_req = 1'b0;
        gap_k   = 2;
        while (!tx_dv && gap_k < 12) begin
            @(negedge clk);
            gap_k++;
        end
        check("gap_done_to_dv", gap_k, GAP + 2);
        @(negedge clk);
        h_done = 1'b1;
        @(negedge clk);
        h_done = 1'b0;
        repeat (5) @(negedge clk);

`ifdef UART_TX_ARBITER_TIMEOUT_EN
        cpu_req  = 1'b1;
        cpu_byte = 8'h99;
        sb.push_back('{GRANT_CPU, 8'h99});
        @(negedge clk);
        cpu_req = 1'b0;
        wait_dv(4, "tmo_launch");
        repeat (TMO) @(negedge clk);
        check("tmo_err_not_yet", {31'd0, err}, 0);
        @(negedge clk);
        check("tmo_err_set", {31'd0, err}, 1);
        check("tmo_cpu_ready", {31'd0, cpu_ready}, 1);
        cpu_req  = 1'b1;
        cpu_byte = 8'h77;
        sb.push_back('{GRANT_CPU, 8'h77});
        @(negedge clk);
        cpu_req = 1'b0;
        wait_dv(8, "tmo_fsm_proceeds");
        @(negedge clk);
        h_done = 1'b1;
        @(negedge clk);
        h_done = 1'b0;
        check("tmo_err_sticky", {31'd0, err}, 1);
        repeat (5) @(negedge clk);
`endif

        // Burst limit: CPU x4, then debug, then CPU
        auto_uart = 1'b1;
        ack0 = ack_count;
        for (int k = 0; k < 4; k++) sb.push_back('{GRANT_CPU, 8'(32'h50 + k)});
        sb.push_back('{GRANT_DBG, 8'h7E});
        sb.push_back('{GRANT_CPU, 8'h54});
        sb.push_back('{GRANT_CPU, 8'h55});
        dbg_req  = 1'b1;
        dbg_byte = 8'h7E;
        cpu_req  = 1'b1;
        cpu_byte = 8'h50;
        sent     = 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            if (dbg_ack) dbg_req = 1'b0;
            if (cpu_ready && sent < 6) begin
                cpu_req  = 1'b1;
                cpu_byte = 8'(32'h50 + sent);
                sent++;
            end
            if (sb.size() == 0 && sent == 6 && grant == GRANT_NONE) break;
        end
        repeat (8) @(negedge clk);
        check("burst_all_sent", sb.size(), 0);
        check("burst_single_ack", ack_count - ack0, 1);
        auto_uart = 1'b0;

        // Round-robin instance with both sources always full
        @(posedge clk);
        #1 rr_run = 1'b1;
        for (int cyc = 0; cyc < 400 && rr_grants.size() < 4; cyc++) @(negedge clk);
        rr_run = 1'b0;
        check("rr_grant_count", (rr_grants.size() >= 4) ? 32'd1 : 32'd0, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_grant%0d", i),
                  {30'd0, (i < rr_grants.size()) ? rr_grants[i] : 2'b11},
                  {30'd0, (i % 2 == 0) ? GRANT_CPU : GRANT_DBG});
        end

`ifndef UART_TX_ARBITER_TIMEOUT_EN
        check("err_tied_low", {31'd0, err}, 0);
`endif
        check("sb_empty_at_end", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete, errors=%0d", errors);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
